mx_block_unpacker: RTL

Receive-side companion to `mx_alu_wrapper`: accepts one packed MXFP8 block (shared E8M0 scale plus K elements, as produced on `vec_out`) through a valid/ready handshake and streams the elements out one per handshake, index 0 first. Each emitted element carries the block scale, its index, a last flag and FP8 class flags. Used by the ALU result path and by benches to read back blocks element-by-element.

---
 rtl/mx_block_unpacker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mx_block_unpacker.sv
// mx_block_unpacker
// Accepts one packed MXFP8 block (shared E8M0 scale in the top w bits, k
// elements of d bits below it, element i at [i*d +: d]) and streams the
// elements out one per handshake, index 0 first. Each presented element
// carries the block scale, its index, a last flag and FP8 class flags.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high; a source holding valid keeps its payload
// stable until that edge. blk_ready_o depends combinationally on
// elem_ready_i so a new block can load on the final element handshake.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   blk_valid_i     : packed block offered
//   blk_ready_o     : block accepted on this edge if blk_valid_i
//   blk_data_i      : {scale, elem[k-1], ..., elem[0]}
//   dtype_i         : 0 = E4M3, 1 = E5M2, others unclassified
//   elem_valid_o    : element presented
//   elem_ready_i    : downstream takes the element
//   elem_o, scale_o, idx_o, last_o : element, block scale, index, final flag
//   is_zero_o, is_inf_o, is_nan_o  : class of elem_o for the latched dtype
//   scale_nan_o     : latched scale is 0xFF
//   state_o         : FSM state (0 = IDLE, 1 = STREAM)
module mx_block_unpacker #(
  parameter int d = 8,
  parameter int k = 32,
  parameter int w = 8,
  localparam int iw = (k > 1) ? $clog2(k) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid_i,
  output logic             blk_ready_o,
  input  logic [k*d+w-1:0] blk_data_i,
  input  logic [2:0]       dtype_i,
  output logic             elem_valid_o,
  input  logic             elem_ready_i,
  output logic [d-1:0]     elem_o,
  output logic [w-1:0]     scale_o,
  output logic [iw-1:0]    idx_o,
  output logic             last_o,
  output logic             is_zero_o,
  output logic             is_inf_o,
  output logic             is_nan_o,
  output logic             scale_nan_o,
  output logic             state_o
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [iw-1:0] idx_max = iw'(k - 1);

  state_t          state_q, state_d;
  logic [k*d-1:0]  buf_q;
  logic [w-1:0]    scale_q;
  logic [2:0]      dtype_q;
  logic [iw-1:0]   idx_q;

  logic            streaming;
  logic            at_last;
  logic            elem_hs;
  logic            load;
  logic [d-1:0]    elem_raw;

  assign streaming = (state_q == STREAM);
  assign at_last   = streaming && (idx_q == idx_max);

  // Next-state and handshake decode.
  always_comb begin
    state_d      = state_q;
    blk_ready_o  = 1'b0;
    elem_valid_o = 1'b0;
    elem_hs      = 1'b0;
    load         = 1'b0;
    case (state_q)
      IDLE: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin
          load    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        elem_valid_o = 1'b1;
        elem_hs      = elem_ready_i;
        // The final element handshake frees the buffer in the same edge,
        // so a waiting block loads with no bubble.
        if (elem_ready_i && at_last) begin
          blk_ready_o = 1'b1;
          if (blk_valid_i) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      scale_q <= '0;
      dtype_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      buf_q   <= blk_data_i[k*d-1:0];
      scale_q <= blk_data_i[k*d+w-1:k*d];
      dtype_q <= dtype_i;
      idx_q   <= '0;
    end else if (elem_hs) begin
      // Wrap only through the final handshake; never count past k-1.
      idx_q <= at_last ? '0 : idx_q + iw'(1);
    end
  end

  assign elem_raw = buf_q[int'(idx_q)*d +: d];

  // Element-side outputs read as zero while idle.
  assign elem_o      = streaming ? elem_raw : '0;
  assign scale_o     = streaming ? scale_q : '0;
  assign idx_o       = streaming ? idx_q : '0;
  assign last_o      = at_last;
  assign scale_nan_o = streaming && (&scale_q);
  assign state_o     = state_q;

  // FP8 class decode; the sign bit (bit 7) is ignored throughout.
  always_comb begin
    is_zero_o = 1'b0;
    is_inf_o  = 1'b0;
    is_nan_o  = 1'b0;
    if (streaming) begin
      case (dtype_q)
        3'd0: begin // E4M3: exp [6:3], mant [2:0]; no infinity encoding
          is_nan_o  = (elem_o[6:3] == 4'hF) && (elem_o[2:0] == 3'h7);
          is_zero_o = (elem_o[6:0] == 7'h00);
        end
        3'd1: begin // E5M2: exp [6:2], mant [1:0]
          is_inf_o  = (elem_o[6:2] == 5'h1F) && (elem_o[1:0] == 2'b00);
          is_nan_o  = (elem_o[6:2] == 5'h1F) && (elem_o[1:0] != 2'b00);
          is_zero_o = (elem_o[6:0] == 7'h00);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
